// File: rtl/ysyx_23060020_pkg.sv
// Shared definitions for the ysyx_23060020 core: fetch FSM encoding,
// bus response codes and the instruction encodings the core checks for.
package ysyx_23060020_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_REQ    = 2'd1;
    localparam state_t ST_WAIT_R = 2'd2;
    localparam state_t ST_HOLD   = 2'd3;

    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam logic [31:0] NOP_ENC    = 32'h0000_0013;
    localparam logic [31:0] EBREAK_ENC = 32'h0010_0073;

    // Only word-aligned fetch addresses may go out on the bus.
    function automatic logic word_aligned(input logic [1:0] low_bits);
        return low_bits == 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_23060020_ifu.sv
// Instruction fetch unit: one AXI4-Lite-style read per fetch, holds the
// returned word on inst until the core retires it.
module ysyx_23060020_ifu
    import ysyx_23060020_pkg::*;
#(
    parameter logic [31:0] NOP_INST = NOP_ENC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        pc_valid,
    input  logic        flush,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic        fetch_err,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output state_t      dbg_state
);

    // Every channel (AR, R, inst) transfers on a rising edge where valid and
    // ready are both high; a valid, once raised, holds its payload until then.

    state_t      state;
    state_t      state_nxt;
    logic [31:0] araddr_nxt;
    logic [31:0] inst_nxt;
    logic        fetch_err_nxt;
    logic        drop;
    logic        drop_nxt;
    logic        launch;

    always_comb begin
        state_nxt     = state;
        araddr_nxt    = araddr;
        inst_nxt      = inst;
        fetch_err_nxt = fetch_err;
        drop_nxt      = drop;
        launch        = 1'b0;

        case (state)
            ST_IDLE: begin
                launch = pc_valid && !flush;
            end

            ST_REQ: begin
                // The address cannot be withdrawn; remember to discard its data.
                if (flush) begin
                    drop_nxt = 1'b1;
                end
                if (arvalid && arready) begin
                    state_nxt = ST_WAIT_R;
                end
            end

            ST_WAIT_R: begin
                if (rvalid) begin
                    if (drop || flush) begin
                        state_nxt = ST_IDLE;
                        drop_nxt  = 1'b0;
                    end else begin
                        state_nxt = ST_HOLD;
                        if (rresp != RESP_OKAY) begin
                            inst_nxt      = NOP_INST;
                            fetch_err_nxt = 1'b1;
                        end else begin
                            inst_nxt      = rdata;
                            fetch_err_nxt = 1'b0;
                        end
                    end
                end else if (flush) begin
                    drop_nxt = 1'b1;
                end
            end

            ST_HOLD: begin
                if (flush) begin
                    state_nxt     = ST_IDLE;
                    inst_nxt      = NOP_INST;
                    fetch_err_nxt = 1'b0;
                end else if (inst_ready) begin
                    if (pc_valid) begin
                        launch = 1'b1;
                    end else begin
                        state_nxt     = ST_IDLE;
                        inst_nxt      = NOP_INST;
                        fetch_err_nxt = 1'b0;
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // A misaligned pc never reaches the bus; it becomes a held fault.
        if (launch) begin
            araddr_nxt = pc;
            inst_nxt   = NOP_INST;
            if (word_aligned(pc[1:0])) begin
                state_nxt     = ST_REQ;
                fetch_err_nxt = 1'b0;
            end else begin
                state_nxt     = ST_HOLD;
                fetch_err_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            araddr     <= 32'h0;
            inst       <= NOP_INST;
            fetch_err  <= 1'b0;
            drop       <= 1'b0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            inst_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            araddr     <= araddr_nxt;
            inst       <= inst_nxt;
            fetch_err  <= fetch_err_nxt;
            drop       <= drop_nxt;
            arvalid    <= (state_nxt == ST_REQ);
            rready     <= (state_nxt == ST_WAIT_R);
            inst_valid <= (state_nxt == ST_HOLD);
        end
    end

    assign dbg_state = state;

endmodule
